// File: rtl/blocking_cache_pkg.sv
// Shared types and constants for the baseline blocking cache controller.
package blocking_cache_pkg;
  localparam int nbl = 16;
  localparam int idw = 4;
  localparam int ofw = 4;

  localparam logic [2:0] c_type_read  = 3'd0;
  localparam logic [2:0] c_type_write = 3'd1;
  localparam logic [2:0] c_type_init  = 3'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_TC, S_IN, S_RD, S_WD, S_EP, S_ER, S_EW, S_RR, S_RW, S_RU, S_WT
  } state_e;
endpackage

// File: rtl/blocking_cache_base_ctrl_if.sv
// val/rdy handshakes between the cache controller and its requester and memory.
interface blocking_cache_base_ctrl_if;
  logic cachereq_val,  cachereq_rdy;
  logic cacheresp_val, cacheresp_rdy;
  logic memreq_val,    memreq_rdy;
  logic memresp_val,   memresp_rdy;

  modport master (
    input  cachereq_val, cacheresp_rdy, memreq_rdy, memresp_val,
    output cachereq_rdy, cacheresp_val, memreq_val, memresp_rdy
  );

  modport slave (
    output cachereq_val, cacheresp_rdy, memreq_rdy, memresp_val,
    input  cachereq_rdy, cacheresp_val, memreq_val, memresp_rdy
  );
endinterface

// File: rtl/cache_vd_bits.sv
// Per-line valid and dirty flops; reports the bits of the currently indexed line.
module cache_vd_bits
  import blocking_cache_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [idw-1:0] idx,
  input  logic           set_valid,
  input  logic           set_dirty,
  input  logic           clr_dirty,
  output logic           line_valid,
  output logic           line_dirty
);
  logic [nbl-1:0] valid_q, valid_d;
  logic [nbl-1:0] dirty_q, dirty_d;

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (set_valid) valid_d[idx] = 1'b1;
    if (set_dirty)      dirty_d[idx] = 1'b1;
    else if (clr_dirty) dirty_d[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  assign line_valid = valid_q[idx];
  assign line_dirty = dirty_q[idx];
endmodule

// File: rtl/blocking_cache_base_ctrl.sv
// Control FSM for the 256 B direct-mapped write-back, write-allocate blocking cache.
// IDLE wait req | TC tag check | IN init write | RD/WD data read/write | EP/ER/EW evict
// RR/RW refill request/wait | RU refill update | WT wait for response accept
module blocking_cache_base_ctrl
  import blocking_cache_pkg::*;
#(
  parameter int p_idx_shamt = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  blocking_cache_base_ctrl_if.master        bus,
  output logic                              cachereq_en,
  output logic                              memresp_en,
  output logic                              write_data_mux_sel,
  output logic                              tag_array_ren,
  output logic                              tag_array_wen,
  output logic                              data_array_ren,
  output logic                              data_array_wen,
  output logic [15:0]                       data_array_wben,
  output logic                              read_data_reg_en,
  output logic                              evict_addr_reg_en,
  output logic                              memreq_addr_mux_sel,
  output logic [1:0]                        hit,
  output logic [2:0]                        read_word_mux_sel,
  output logic [2:0]                        cacheresp_type,
  output logic [2:0]                        memreq_type,
  input  logic [2:0]                        cachereq_type,
  input  logic [31:0]                       cachereq_addr,
  input  logic                              tag_match
);
  state_e         state_q, state_d;
  logic           hit_q, hit_d;
  logic [idw-1:0] idx;
  logic [1:0]     off;
  logic [15:0]    wben_word;
  logic           is_write, is_init, is_read, tc_hit;
  logic           line_valid, line_dirty;
  logic [31:0]    unused_addr;

  assign unused_addr = cachereq_addr;
  assign idx         = cachereq_addr[4+p_idx_shamt +: idw];
  assign off         = cachereq_addr[3:2];
  assign wben_word   = 16'h000F << {off, 2'b00};
  // Unknown types fall through to READ behaviour.
  assign is_write    = (cachereq_type == c_type_write);
  assign is_init     = (cachereq_type == c_type_init);
  assign is_read     = !is_write && !is_init;
  assign tc_hit      = line_valid & tag_match;

  cache_vd_bits u_vd (
    .clk        (clk),
    .reset      (reset),
    .idx        (idx),
    .set_valid  ((state_q == S_IN) || (state_q == S_RU)),
    .set_dirty  (state_q == S_WD),
    .clr_dirty  ((state_q == S_IN) || (state_q == S_RU)),
    .line_valid (line_valid),
    .line_dirty (line_dirty)
  );

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    case (state_q)
      S_IDLE: if (bus.cachereq_val) state_d = S_TC;
      S_TC: begin
        hit_d = tc_hit;
        if (is_init)                       state_d = S_IN;
        else if (tc_hit)                   state_d = is_write ? S_WD : S_RD;
        else if (line_valid && line_dirty) state_d = S_EP;
        else                               state_d = S_RR;
      end
      S_IN: begin
        hit_d   = 1'b0;
        state_d = S_WT;
      end
      S_RD, S_WD: state_d = S_WT;
      S_EP:       state_d = S_ER;
      S_ER:       if (bus.memreq_rdy)    state_d = S_EW;
      S_EW:       if (bus.memresp_val)   state_d = S_RR;
      S_RR:       if (bus.memreq_rdy)    state_d = S_RW;
      S_RW:       if (bus.memresp_val)   state_d = S_RU;
      S_RU:       state_d = is_write ? S_WD : S_RD;
      S_WT:       if (bus.cacheresp_rdy) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    bus.cachereq_rdy    = 1'b0;
    bus.cacheresp_val   = 1'b0;
    bus.memreq_val      = 1'b0;
    bus.memresp_rdy     = 1'b0;
    cachereq_en         = 1'b0;
    memresp_en          = 1'b0;
    write_data_mux_sel  = 1'b0;
    tag_array_ren       = 1'b0;
    tag_array_wen       = 1'b0;
    data_array_ren      = 1'b0;
    data_array_wen      = 1'b0;
    data_array_wben     = 16'h0000;
    read_data_reg_en    = 1'b0;
    evict_addr_reg_en   = 1'b0;
    memreq_addr_mux_sel = 1'b0;
    read_word_mux_sel   = 3'd0;
    cacheresp_type      = 3'd0;
    memreq_type         = 3'd0;
    hit                 = {1'b0, hit_q};
    case (state_q)
      S_IDLE: begin
        bus.cachereq_rdy = 1'b1;
        cachereq_en      = bus.cachereq_val;
      end
      S_TC: tag_array_ren = 1'b1;
      S_IN, S_WD: begin
        tag_array_wen   = (state_q == S_IN);
        data_array_wen  = 1'b1;
        data_array_wben = wben_word;
      end
      S_RD: begin
        data_array_ren   = 1'b1;
        read_data_reg_en = 1'b1;
      end
      S_EP: begin
        tag_array_ren     = 1'b1;
        data_array_ren    = 1'b1;
        read_data_reg_en  = 1'b1;
        evict_addr_reg_en = 1'b1;
      end
      S_ER: begin
        bus.memreq_val = 1'b1;
        memreq_type    = c_type_write;
      end
      S_EW: bus.memresp_rdy = 1'b1;
      S_RR: begin
        bus.memreq_val      = 1'b1;
        memreq_type         = c_type_read;
        memreq_addr_mux_sel = 1'b1;
      end
      S_RW: begin
        bus.memresp_rdy = 1'b1;
        memresp_en      = bus.memresp_val;
      end
      S_RU: begin
        tag_array_wen      = 1'b1;
        data_array_wen     = 1'b1;
        data_array_wben    = 16'hFFFF;
        write_data_mux_sel = 1'b1;
      end
      S_WT: begin
        bus.cacheresp_val = 1'b1;
        cacheresp_type    = cachereq_type;
        read_word_mux_sel = is_read ? (3'd3 - {1'b0, off}) : 3'd4;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_blocking_cache_base_ctrl.sv
// Bench for blocking_cache_base_ctrl: behavioural datapath and memory around the controller,
// expected memory requests and cache responses queued per transaction and checked as they appear.
module tb_blocking_cache_base_ctrl;
  import blocking_cache_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  blocking_cache_base_ctrl_if bus ();

  logic        cachereq_en, memresp_en, write_data_mux_sel;
  logic        tag_array_ren, tag_array_wen, data_array_ren, data_array_wen;
  logic [15:0] data_array_wben;
  logic        read_data_reg_en, evict_addr_reg_en, memreq_addr_mux_sel;
  logic [1:0]  hit;
  logic [2:0]  read_word_mux_sel, cacheresp_type, memreq_type;
  logic [2:0]  cachereq_type;
  logic [31:0] cachereq_addr;
  logic        tag_match;

  blocking_cache_base_ctrl #(.p_idx_shamt(0)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cachereq_en(cachereq_en), .memresp_en(memresp_en), .write_data_mux_sel(write_data_mux_sel),
    .tag_array_ren(tag_array_ren), .tag_array_wen(tag_array_wen),
    .data_array_ren(data_array_ren), .data_array_wen(data_array_wen),
    .data_array_wben(data_array_wben), .read_data_reg_en(read_data_reg_en),
    .evict_addr_reg_en(evict_addr_reg_en), .memreq_addr_mux_sel(memreq_addr_mux_sel),
    .hit(hit), .read_word_mux_sel(read_word_mux_sel), .cacheresp_type(cacheresp_type),
    .memreq_type(memreq_type), .cachereq_type(cachereq_type), .cachereq_addr(cachereq_addr),
    .tag_match(tag_match)
  );

  // Behavioural datapath
  logic         model_init = 1'b1;
  logic [2:0]   tb_type = 3'd0;
  logic [31:0]  tb_addr = 32'h0, tb_data = 32'h0;
  logic [127:0] tb_memresp_data = '0;
  logic [31:0]  req_data_r, evict_addr_r;
  logic [127:0] read_data_r, refill_r;
  logic [23:0]  tag_arr [16];
  logic [127:0] data_arr [16];
  logic [3:0]   m_idx;
  logic [127:0] wdata, memreq_data;
  logic [31:0]  memreq_addr, cacheresp_data;

  assign m_idx       = cachereq_addr[7:4];
  assign tag_match   = (tag_arr[m_idx] == cachereq_addr[31:8]);
  assign wdata       = write_data_mux_sel ? refill_r : {4{req_data_r}};
  assign memreq_addr = memreq_addr_mux_sel ? {cachereq_addr[31:4], 4'h0} : evict_addr_r;
  assign memreq_data = read_data_r;

  always_comb begin
    cacheresp_data = 32'h0;
    case (read_word_mux_sel)
      3'd0: cacheresp_data = read_data_r[127:96];
      3'd1: cacheresp_data = read_data_r[95:64];
      3'd2: cacheresp_data = read_data_r[63:32];
      3'd3: cacheresp_data = read_data_r[31:0];
      default: cacheresp_data = 32'h0;
    endcase
  end

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] nw,
                                         input logic [15:0] be);
    logic [127:0] r;
    r = old;
    for (int b = 0; b < 16; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (model_init) begin
      cachereq_type <= 3'd0;
      cachereq_addr <= 32'h0;
      req_data_r    <= 32'h0;
      read_data_r   <= '0;
      refill_r      <= '0;
      evict_addr_r  <= 32'h0;
      for (int i = 0; i < 16; i++) begin
        tag_arr[i]  <= 24'hFFFFFF;
        data_arr[i] <= '0;
      end
    end else begin
      if (cachereq_en) begin
        cachereq_type <= tb_type;
        cachereq_addr <= tb_addr;
        req_data_r    <= tb_data;
      end
      if (memresp_en)        refill_r <= tb_memresp_data;
      if (tag_array_wen)     tag_arr[m_idx] <= cachereq_addr[31:8];
      if (data_array_wen)    data_arr[m_idx] <= merge(data_arr[m_idx], wdata, data_array_wben);
      if (read_data_reg_en)  read_data_r <= data_arr[m_idx];
      if (evict_addr_reg_en) evict_addr_r <= {tag_arr[m_idx], m_idx, 4'h0};
    end
  end

  // Memory contents and scoreboard
  logic [127:0] mem [logic [31:0]];

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] addr;
    int          wsel;
    logic [31:0] wval;
  } mreq_t;

  typedef struct {
    logic [2:0]  typ;
    logic [1:0]  test;
    logic [31:0] data;
    int          lat;
  } resp_t;

  mreq_t mreq_q[$];
  resp_t resp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic run_txn(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] data,
                         input int mem_stall, input int resp_stall);
    int cyc, mwait, rwait, lat;
    bit mactive, ractive, pend, done;
    logic [127:0] pline;
    mreq_t em;
    resp_t er;
    cyc = 0; mwait = 0; rwait = 0; lat = 0;
    mactive = 0; ractive = 0; pend = 0; done = 0; pline = '0;
    @(negedge clk);
    tb_type = typ; tb_addr = addr; tb_data = data;
    bus.cachereq_val = 1'b1;
    #1;
    checks++;
    if (bus.cachereq_rdy !== 1'b1 || cachereq_en !== 1'b1) begin
      failures++;
      $display("FAIL accept addr=%h rdy=%b en=%b expected 1 1", addr, bus.cachereq_rdy, cachereq_en);
    end
    @(posedge clk);
    #1 bus.cachereq_val = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.memreq_rdy = 1'b0; bus.memresp_val = 1'b0; bus.cacheresp_rdy = 1'b0;
      if (pend && bus.memresp_rdy) begin
        bus.memresp_val = 1'b1;
        tb_memresp_data = pline;
        pend = 0;
      end
      if (mactive) begin
        checks++;
        if (bus.memreq_val !== 1'b1 || mreq_q.size() == 0 ||
            memreq_addr_mux_sel !== (mreq_q[0].typ == c_type_read)) begin
          failures++;
          $display("FAIL memreq_hold val=%b sel=%b expected val=1 with stable sel", bus.memreq_val,
                   memreq_addr_mux_sel);
        end
      end
      if (bus.memreq_val) begin
        if (!mactive) begin mactive = 1; mwait = 0; end
        if (mwait < mem_stall) mwait++;
        else begin
          bus.memreq_rdy = 1'b1;
          mactive = 0;
          checks++;
          if (mreq_q.size() == 0) begin
            failures++;
            $display("FAIL memreq_unexpected type=%0d addr=%h expected none", memreq_type, memreq_addr);
          end else begin
            em = mreq_q.pop_front();
            if (memreq_type !== em.typ || memreq_addr !== em.addr ||
                (em.wsel >= 0 && memreq_data[32*em.wsel +: 32] !== em.wval)) begin
              failures++;
              $display("FAIL memreq type=%0d addr=%h line=%h expected type=%0d addr=%h word%0d=%h",
                       memreq_type, memreq_addr, memreq_data, em.typ, em.addr, em.wsel, em.wval);
            end
          end
          if (memreq_type == c_type_write) begin
            mem[memreq_addr] = memreq_data;
            pline = '0;
          end else pline = mem_line(memreq_addr);
          pend = 1;
        end
      end
      if (ractive) begin
        checks++;
        if (bus.cacheresp_val !== 1'b1 || bus.cachereq_rdy !== 1'b0) begin
          failures++;
          $display("FAIL resp_hold val=%b req_rdy=%b expected 1 0", bus.cacheresp_val, bus.cachereq_rdy);
        end
      end
      if (bus.cacheresp_val) begin
        if (!ractive) begin ractive = 1; rwait = 0; lat = cyc; end
        if (rwait < resp_stall) rwait++;
        else begin
          bus.cacheresp_rdy = 1'b1;
          done = 1;
          checks++;
          if (resp_q.size() == 0) begin
            failures++;
            $display("FAIL resp_unexpected addr=%h expected none", addr);
          end else begin
            er = resp_q.pop_front();
            if (cacheresp_type !== er.typ || hit !== er.test || cacheresp_data !== er.data ||
                (er.lat >= 0 && lat != er.lat)) begin
              failures++;
              $display("FAIL resp addr=%h type=%0d test=%0d data=%h lat=%0d expected %0d %0d %h %0d",
                       addr, cacheresp_type, hit, cacheresp_data, lat, er.typ, er.test, er.data, er.lat);
            end
          end
        end
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL txn_timeout addr=%h cycles=%0d expected response within 100", addr, cyc);
    end
    @(negedge clk);
    bus.memreq_rdy = 1'b0; bus.memresp_val = 1'b0; bus.cacheresp_rdy = 1'b0;
    #1;
    checks++;
    if (bus.cachereq_rdy !== 1'b1 || bus.cacheresp_val !== 1'b0 || mreq_q.size() != 0) begin
      failures++;
      $display("FAIL back_to_idle req_rdy=%b resp_val=%b pending_memreq=%0d expected 1 0 0",
               bus.cachereq_rdy, bus.cacheresp_val, mreq_q.size());
      mreq_q.delete();
    end
  endtask

  task automatic test_reset;
    bus.cachereq_val = 1'b0; bus.cacheresp_rdy = 1'b0;
    bus.memreq_rdy = 1'b0;   bus.memresp_val = 1'b0;
    repeat (3) @(posedge clk);
    model_init = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.cachereq_rdy !== 1'b1 || bus.cacheresp_val !== 1'b0 || bus.memreq_val !== 1'b0 ||
        bus.memresp_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake req_rdy=%b resp_val=%b mreq_val=%b mresp_rdy=%b expected 1 0 0 0",
               bus.cachereq_rdy, bus.cacheresp_val, bus.memreq_val, bus.memresp_rdy);
    end
    checks++;
    if ({cachereq_en, memresp_en, write_data_mux_sel, tag_array_ren, tag_array_wen, data_array_ren,
         data_array_wen, read_data_reg_en, evict_addr_reg_en, memreq_addr_mux_sel} !== 10'b0 ||
        data_array_wben !== 16'h0 || hit !== 2'd0 || read_word_mux_sel !== 3'd0 ||
        cacheresp_type !== 3'd0 || memreq_type !== 3'd0) begin
      failures++;
      $display("FAIL reset_strobes wben=%h hit=%0d rwms=%0d expected all zero", data_array_wben, hit,
               read_word_mux_sel);
    end
    reset = 1'b0;
  endtask

  task automatic test_init_read_hit;
    resp_q.push_back('{typ: c_type_init, test: 2'd0, data: 32'h0, lat: 3});
    run_txn(c_type_init, 32'h0000_1000, 32'hdeadbeef, 0, 0);
    resp_q.push_back('{typ: c_type_read, test: 2'd1, data: 32'hdeadbeef, lat: 3});
    run_txn(c_type_read, 32'h0000_1000, 32'h0, 0, 0);
  endtask

  task automatic test_read_miss;
    mem[32'h0000_2000] = {32'h4, 32'h3, 32'h2, 32'h1};
    mreq_q.push_back('{typ: c_type_read, addr: 32'h0000_2000, wsel: -1, wval: 32'h0});
    resp_q.push_back('{typ: c_type_read, test: 2'd0, data: 32'h2, lat: 6});
    run_txn(c_type_read, 32'h0000_2004, 32'h0, 0, 0);
    resp_q.push_back('{typ: c_type_read, test: 2'd1, data: 32'h2, lat: 3});
    run_txn(c_type_read, 32'h0000_2004, 32'h0, 0, 0);
    resp_q.push_back('{typ: 3'd3, test: 2'd1, data: 32'h3, lat: 3});
    run_txn(3'd3, 32'h0000_2008, 32'h0, 0, 0);
  endtask

  task automatic test_evict;
    resp_q.push_back('{typ: c_type_init, test: 2'd0, data: 32'h0, lat: 3});
    run_txn(c_type_init, 32'h0000_1000, 32'h1111_1111, 0, 0);
    resp_q.push_back('{typ: c_type_write, test: 2'd1, data: 32'h0, lat: 3});
    run_txn(c_type_write, 32'h0000_1008, 32'hcafe0000, 0, 0);
    mreq_q.push_back('{typ: c_type_write, addr: 32'h0000_1000, wsel: 2, wval: 32'hcafe0000});
    mreq_q.push_back('{typ: c_type_read,  addr: 32'h0000_3000, wsel: -1, wval: 32'h0});
    resp_q.push_back('{typ: c_type_read, test: 2'd0, data: 32'h0000_3000, lat: 9});
    run_txn(c_type_read, 32'h0000_3000, 32'h0, 0, 0);
  endtask

  task automatic test_memreq_stall;
    resp_q.push_back('{typ: c_type_write, test: 2'd1, data: 32'h0, lat: 3});
    run_txn(c_type_write, 32'h0000_3004, 32'h0000_0055, 0, 0);
    mreq_q.push_back('{typ: c_type_write, addr: 32'h0000_3000, wsel: 1, wval: 32'h0000_0055});
    mreq_q.push_back('{typ: c_type_read,  addr: 32'h0000_1000, wsel: -1, wval: 32'h0});
    resp_q.push_back('{typ: c_type_read, test: 2'd0, data: 32'h1111_1111, lat: -1});
    run_txn(c_type_read, 32'h0000_1000, 32'h0, 3, 0);
  endtask

  task automatic test_resp_backpressure;
    resp_q.push_back('{typ: c_type_read, test: 2'd1, data: 32'h1111_1111, lat: 3});
    run_txn(c_type_read, 32'h0000_1000, 32'h0, 0, 5);
  endtask

  task automatic test_reset_in_rw;
    int cyc;
    bit in_rw;
    mreq_t em;
    cyc = 0; in_rw = 0;
    mreq_q.push_back('{typ: c_type_read, addr: 32'h0000_4010, wsel: -1, wval: 32'h0});
    @(negedge clk);
    tb_type = c_type_read; tb_addr = 32'h0000_4010; tb_data = 32'h0;
    bus.cachereq_val = 1'b1;
    @(posedge clk);
    #1 bus.cachereq_val = 1'b0;
    while (!in_rw && cyc < 50) begin
      @(negedge clk);
      cyc++;
      bus.memreq_rdy = 1'b0;
      if (bus.memresp_rdy) in_rw = 1;
      else if (bus.memreq_val) begin
        bus.memreq_rdy = 1'b1;
        em = mreq_q.pop_front();
        checks++;
        if (memreq_type !== em.typ || memreq_addr !== em.addr) begin
          failures++;
          $display("FAIL rw_memreq type=%0d addr=%h expected %0d %h", memreq_type, memreq_addr,
                   em.typ, em.addr);
        end
      end
    end
    checks++;
    if (!in_rw) begin
      failures++;
      $display("FAIL rw_reach_timeout cycles=%0d expected memresp_rdy within 50", cyc);
      mreq_q.delete();
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.memresp_rdy !== 1'b0 || bus.cachereq_rdy !== 1'b1 || bus.memreq_val !== 1'b0 || hit !== 2'd0) begin
      failures++;
      $display("FAIL reset_in_rw mresp_rdy=%b req_rdy=%b mreq_val=%b hit=%0d expected 0 1 0 0",
               bus.memresp_rdy, bus.cachereq_rdy, bus.memreq_val, hit);
    end
    @(negedge clk);
    reset = 1'b0;
    mreq_q.push_back('{typ: c_type_read, addr: 32'h0000_4010, wsel: -1, wval: 32'h0});
    resp_q.push_back('{typ: c_type_read, test: 2'd0, data: 32'h0000_4010, lat: 6});
    run_txn(c_type_read, 32'h0000_4010, 32'h0, 0, 0);
    // Line 0 held 0x1000 before reset; it must now refill without a writeback.
    mreq_q.push_back('{typ: c_type_read, addr: 32'h0000_1000, wsel: -1, wval: 32'h0});
    resp_q.push_back('{typ: c_type_read, test: 2'd0, data: 32'h1111_1111, lat: 6});
    run_txn(c_type_read, 32'h0000_1000, 32'h0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_init_read_hit();
    test_read_miss();
    test_evict();
    test_memreq_stall();
    test_resp_backpressure();
    test_reset_in_rw();
    checks++;
    if (resp_q.size() != 0 || mreq_q.size() != 0) begin
      failures++;
      $display("FAIL leftover resp=%0d memreq=%0d expected 0 0", resp_q.size(), mreq_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t expected bench to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/blocking_cache_base_ctrl.md
Name: blocking_cache_base_ctrl

Overview:
FSM control unit for the baseline blocking cache datapath: a 256 B, direct-mapped cache with 16 lines of 16 B, write-back and write-allocate.
- Sequences tag/data SRAM access, eviction, refill and response.
- Owns the per-line valid and dirty bits.
- Drives the val/rdy handshakes on cachereq, cacheresp, memreq and memresp; all message payloads come from the datapath.

Parameters:
p_idx_shamt, 0, index bit shift; idx = cachereq_addr[4+p_idx_shamt +: 4]

Ports:
Interface rules: one clock `clk`; reset is synchronous and active-high, port `reset`.
clk  in  1  clock
reset  in  1  synchronous active-high reset
cachereq_val/cachereq_rdy  in/out  1/1  cache request handshake
cacheresp_val/cacheresp_rdy  out/in  1/1  cache response handshake
memreq_val/memreq_rdy  out/in  1/1  memory request handshake
memresp_val/memresp_rdy  in/out  1/1  memory response handshake
cachereq_en, memresp_en  out  1  datapath input register enables
write_data_mux_sel  out  1  0 = replicated request word, 1 = refill line
tag_array_ren, tag_array_wen, data_array_ren, data_array_wen  out  1  SRAM strobes
data_array_wben  out  16  byte write enables
read_data_reg_en, evict_addr_reg_en  out  1  register enables
memreq_addr_mux_sel  out  1  0 = evict address, 1 = line-aligned request address
hit  out  2  cacheresp test field
read_word_mux_sel  out  3  word select; 4 = zero
cacheresp_type, memreq_type  out  3  message types (READ=0, WRITE=1, INIT=2)
cachereq_type  in  3  registered request type
cachereq_addr  in  32  registered request address
tag_match  in  1  stored tag equals request tag

Behaviour:
- Reset:
  - state=IDLE; valid[15:0]=0, dirty[15:0]=0, hit_reg=0.
  - Every output is 0 except cachereq_rdy=1.
  - Reset asserted in any state aborts the operation; valid/dirty are cleared.
- Outputs are a combinational function of state and inputs. Any strobe not listed for a state is 0.
- Derived values:
  - idx as defined under Parameters.
  - off = cachereq_addr[3:2].
  - wben_word = 16'hF << (4*off).
  - read_word_mux_sel = 3-off for a READ; 4 for WRITE and INIT responses.
  - cacheresp_type = cachereq_type.
  - hit = {1'b0, hit_reg}.
- States:
  - IDLE: cachereq_rdy=1. On val, assert cachereq_en and go to TC.
  - TC: tag_array_ren=1; h = valid[idx] & tag_match; hit_reg <= h.
    - INIT -> IN.
    - h & READ -> RD.
    - h & WRITE -> WD.
    - !h & valid & dirty -> EP.
    - !h otherwise -> RR.
  - IN: tag_array_wen, data_array_wen, wben=wben_word, write_data_mux_sel=0. Set valid[idx]=1, dirty[idx]=0; hit_reg <= 0. -> WT.
  - RD: data_array_ren, read_data_reg_en. -> WT.
  - WD: data_array_wen, wben=wben_word, write_data_mux_sel=0. Set dirty[idx]=1. -> WT.
  - EP: tag_array_ren, data_array_ren, read_data_reg_en, evict_addr_reg_en. -> ER.
  - ER: memreq_val=1, memreq_type=WRITE, addr_sel=0. -> EW on memreq_rdy.
  - EW: memresp_rdy=1. -> RR on memresp_val.
  - RR: memreq_val=1, memreq_type=READ, addr_sel=1. -> RW on memreq_rdy.
  - RW: memresp_rdy=1; memresp_en=memresp_val. -> RU on memresp_val.
  - RU: tag_array_wen, data_array_wen, wben=16'hFFFF, write_data_mux_sel=1. Set valid[idx]=1, dirty[idx]=0. -> RD if READ, else WD.
  - WT: cacheresp_val=1. -> IDLE on cacheresp_rdy.
- Handshakes:
  - A transfer occurs only in a cycle where val & rdy are both high.
  - While a val is asserted, it stays high and the payload-selecting strobes stay stable until rdy arrives.
  - Only one request is outstanding; cachereq_rdy=0 outside IDLE.
- Latency:
  - Read/write hit: response valid 3 cycles after the accept cycle.
  - Clean miss: accept, TC, RR, RW, RU, RD/WD, WT, plus memory wait cycles.
- Out-of-range or unknown type: treated as READ.

Decomposition:
- Shared package, blocking_cache_pkg:
  - state enum (IDLE, TC, IN, RD, WD, EP, ER, EW, RR, RW, RU, WT);
  - nbl=16, idw=4, ofw=4;
  - type constants reused from the mem-msgs definitions.
- One sub-module, cache_vd_bits: 16-entry valid/dirty flop array.
  - Ports: idx, set_valid, set_dirty, clr_dirty.
  - Synchronous reset clear.

Test Plan:
- INIT 0x00001000 data 0xdeadbeef, then READ 0x00001000 -> no memreq; READ resp test=1, data 0xdeadbeef, resp valid 3 cycles after accept.
- READ 0x00002004 cold, memresp line {0x4,0x3,0x2,0x1} (word0=0x1) -> memreq READ addr 0x00002000; resp test=0, data 0x2; second READ hits with test=1.
- After INIT 0x1000, WRITE 0x00001008 data 0xcafe0000 (hit), then READ 0x00003000 (same idx 0) -> memreq WRITE addr 0x00001000 with word2=0xcafe0000, then READ addr 0x00003000; resp test=0.
- memreq_rdy held low 3 cycles in ER -> memreq_val stays 1 and memreq_addr_mux_sel stays 0; transfer on the 4th cycle.
- cacheresp_rdy low 5 cycles in WT -> cacheresp_val held; cachereq_rdy=0 throughout; IDLE the cycle after rdy.
- reset pulsed while in RW -> next cycle IDLE, memresp_rdy=0, cachereq_rdy=1; subsequent READ of the same address misses (test=0).
